// File: rtl/vcache_req_arbiter.sv
// vcache_req_arbiter
//
// Shares one vcache packet port between num_req_p requesters. Requests are
// granted round-robin. The requester ID of every accepted packet goes into a
// small ID FIFO. The vcache returns responses in request order, so the FIFO
// head always names the requester that owns the current response.
//
// Parameters:
//   num_req_p    number of requesters (>= 2)
//   pkt_width_p  packed vcache packet width; set it to the vcache packet width
//   data_width_p response data width
//   els_p        maximum outstanding requests, i.e. ID FIFO depth (>= 2)
//
// Ports:
//   clk_i, reset_n_i         clock and synchronous active-low reset
//   v_i, pkt_i, ready_o      per-requester request side (packet k in slice k)
//   cache_v_o, cache_pkt_o,
//   cache_ready_i            granted request toward the vcache
//   cache_v_i, cache_data_i,
//   cache_yumi_o             response from the vcache
//   resp_v_o, resp_data_o,
//   resp_yumi_i              per-requester response (data is broadcast)
//   outstanding_o            ID FIFO occupancy
//
// Optional build macro VCACHE_REQ_ARBITER_ASSERT_EN adds simulation-only
// protocol checks and per-requester grant counters. It adds no synthesized
// logic.

module vcache_req_arbiter #(
    parameter int num_req_p    = 4,
    parameter int pkt_width_p  = 32,
    parameter int data_width_p = 32,
    parameter int els_p        = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               v_i,
    input  logic [num_req_p*pkt_width_p-1:0]   pkt_i,
    output logic [num_req_p-1:0]               ready_o,
    output logic                               cache_v_o,
    output logic [pkt_width_p-1:0]             cache_pkt_o,
    input  logic                               cache_ready_i,
    input  logic                               cache_v_i,
    input  logic [data_width_p-1:0]            cache_data_i,
    output logic                               cache_yumi_o,
    output logic [num_req_p-1:0]               resp_v_o,
    output logic [data_width_p-1:0]            resp_data_o,
    input  logic [num_req_p-1:0]               resp_yumi_i,
    output logic [$clog2(els_p+1)-1:0]         outstanding_o
);

    localparam int lg_lp    = $clog2(num_req_p);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p+1);

    logic [pkt_width_p-1:0] pkt_arr [num_req_p];

    logic [lg_lp-1:0]    rr_reg, rr_next;
    logic [lg_lp-1:0]    grant_id;
    logic [lg_lp:0]      idx_sum;
    logic                any_v;

    logic [lg_lp-1:0]    id_mem [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ptr_w_lp-1:0] rd_ptr_reg, rd_ptr_next;
    logic [cnt_w_lp-1:0] count_reg, count_next;
    logic [lg_lp-1:0]    head_id;

    logic full, empty, push, pop, ready_common, resp_common;

    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_req
            assign pkt_arr[gi]  = pkt_i[gi*pkt_width_p +: pkt_width_p];
            assign ready_o[gi]  = ready_common & (grant_id == lg_lp'(gi));
            assign resp_v_o[gi] = resp_common & (head_id == lg_lp'(gi));
        end
    endgenerate

    // Round-robin search. The loop walks from lowest to highest priority, so
    // the highest-priority valid requester is the last one written.
    always_comb begin
        grant_id = '0;
        idx_sum  = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            idx_sum = {1'b0, rr_reg} + (lg_lp+1)'(i);
            if (idx_sum >= (lg_lp+1)'(num_req_p)) begin
                idx_sum = idx_sum - (lg_lp+1)'(num_req_p);
            end
            if (v_i[idx_sum[lg_lp-1:0]]) begin
                grant_id = idx_sum[lg_lp-1:0];
            end
        end
    end

    assign any_v   = |v_i;
    assign full    = (count_reg == cnt_w_lp'(els_p));
    assign empty   = (count_reg == '0);
    assign head_id = id_mem[rd_ptr_reg];

    // Every handshake output is gated by reset so it is quiet while reset is held.
    assign ready_common  = reset_n_i & cache_ready_i & ~full;
    assign cache_v_o     = reset_n_i & any_v & ~full;
    assign cache_pkt_o   = pkt_arr[grant_id];
    assign push          = cache_v_o & cache_ready_i;

    assign resp_common   = reset_n_i & cache_v_i & ~empty;
    assign cache_yumi_o  = resp_common & resp_yumi_i[head_id];
    assign pop           = cache_yumi_o;
    assign resp_data_o   = cache_data_i;
    assign outstanding_o = reset_n_i ? count_reg : '0;

    always_comb begin
        rr_next     = rr_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            rr_next     = (grant_id == lg_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
            wr_ptr_next = (wr_ptr_reg == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        // A push never happens when full and a pop never when empty, so no guards are needed.
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_reg     <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rr_reg     <= rr_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // ID storage needs no reset: the pointers and the count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr_reg] <= grant_id;
        end
    end

`ifdef VCACHE_REQ_ARBITER_ASSERT_EN
    logic [num_req_p-1:0]   pending_q;
    logic [pkt_width_p-1:0] pkt_q [num_req_p];
    int unsigned            grant_cnt [num_req_p];

    always @(posedge clk_i) begin
        if (!reset_n_i) begin
            pending_q <= '0;
            for (int k = 0; k < num_req_p; k++) begin
                grant_cnt[k] <= 0;
            end
        end else begin
            if (cache_v_i && empty) begin
                $error("%m @%0t: vcache response with empty ID FIFO", $time);
            end
            if (push && full) begin
                $error("%m @%0t: push into full ID FIFO", $time);
            end
            for (int k = 0; k < num_req_p; k++) begin
                if (resp_yumi_i[k] && !resp_v_o[k]) begin
                    $error("%m @%0t: resp_yumi_i[%0d] without resp_v_o", $time, k);
                end
                if (pending_q[k] && (!v_i[k] || pkt_arr[k] != pkt_q[k])) begin
                    $error("%m @%0t: requester %0d changed before accept", $time, k);
                end
                pending_q[k] <= v_i[k] & ~ready_o[k];
                pkt_q[k]     <= pkt_arr[k];
                if (v_i[k] && ready_o[k]) begin
                    grant_cnt[k] <= grant_cnt[k] + 1;
                end
            end
        end
    end

    always @(negedge reset_n_i) begin
        for (int k = 0; k < num_req_p; k++) begin
            $display("%m: requester %0d grants=%0d", k, grant_cnt[k]);
        end
    end
`endif

endmodule

// File: tb/tb_vcache_req_arbiter.sv
module tb_vcache_req_arbiter;

    localparam int NR = 4;
    localparam int PW = 8;
    localparam int DW = 8;
    localparam int EL = 4;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic [NR-1:0]     v_i;
    logic [NR*PW-1:0]  pkt_i;
    logic [NR-1:0]     ready_o;
    logic              cache_v_o;
    logic [PW-1:0]     cache_pkt_o;
    logic              cache_ready_i;
    logic              cache_v_i;
    logic [DW-1:0]     cache_data_i;
    logic              cache_yumi_o;
    logic [NR-1:0]     resp_v_o;
    logic [DW-1:0]     resp_data_o;
    logic [NR-1:0]     resp_yumi_i;
    logic [2:0]        outstanding_o;

    int checks   = 0;
    int failures = 0;
    int gcnt [NR];
    int acc;
    int exp_id [3];
    int req_seq [3];
    logic [7:0] exp_data [3];

    vcache_req_arbiter #(
        .num_req_p    (NR),
        .pkt_width_p  (PW),
        .data_width_p (DW),
        .els_p        (EL)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .v_i           (v_i),
        .pkt_i         (pkt_i),
        .ready_o       (ready_o),
        .cache_v_o     (cache_v_o),
        .cache_pkt_o   (cache_pkt_o),
        .cache_ready_i (cache_ready_i),
        .cache_v_i     (cache_v_i),
        .cache_data_i  (cache_data_i),
        .cache_yumi_o  (cache_yumi_o),
        .resp_v_o      (resp_v_o),
        .resp_data_o   (resp_data_o),
        .resp_yumi_i   (resp_yumi_i),
        .outstanding_o (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s got=%0h @%0t", tag, got, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_n_i     = 1'b0;
        v_i           = '0;
        pkt_i         = {8'h13, 8'h12, 8'h11, 8'h10};
        cache_ready_i = 1'b1;
        cache_v_i     = 1'b0;
        cache_data_i  = '0;
        resp_yumi_i   = '0;
        for (int k = 0; k < NR; k++) gcnt[k] = 0;

        // Reset: outputs quiet even with active inputs.
        step();
        v_i = 4'b1111; cache_v_i = 1'b1; resp_yumi_i = 4'b1111;
        #2;
        check_eq("rst_ready",   32'(ready_o),       32'h0);
        check_eq("rst_cache_v", 32'(cache_v_o),     32'h0);
        check_eq("rst_resp_v",  32'(resp_v_o),      32'h0);
        check_eq("rst_yumi",    32'(cache_yumi_o),  32'h0);
        check_eq("rst_outst",   32'(outstanding_o), 32'h0);
        step();
        reset_n_i = 1'b1; v_i = '0; cache_v_i = 1'b0; resp_yumi_i = '0;

        // Round-robin fairness: every requester valid, responses consumed at once.
        for (int i = 0; i < 16; i++) begin
            v_i = 4'b1111; cache_v_i = (i > 0); resp_yumi_i = 4'b1111; cache_data_i = 8'(i);
            #2;
            check_eq($sformatf("rr_pkt%0d", i),   32'(cache_pkt_o), 32'h10 + 32'(i % 4));
            check_eq($sformatf("rr_ready%0d", i), 32'(ready_o),     32'(1) << (i % 4));
            if (i > 0) check_eq($sformatf("rr_resp_v%0d", i), 32'(resp_v_o), 32'(1) << ((i - 1) % 4));
            for (int k = 0; k < NR; k++) if (ready_o[k]) gcnt[k]++;
            step();
        end
        for (int k = 0; k < NR; k++) check_eq($sformatf("rr_gcnt%0d", k), 32'(gcnt[k]), 32'd4);
        check_eq("rr_outst", 32'(outstanding_o), 32'd1);
        v_i = '0; cache_v_i = 1'b1;
        #2;
        check_eq("rr_drain_resp_v", 32'(resp_v_o),     32'h8);
        check_eq("rr_drain_yumi",   32'(cache_yumi_o), 32'h1);
        step();
        cache_v_i = 1'b0;
        check_eq("rr_drain_outst", 32'(outstanding_o), 32'd0);

        // Skip idle requesters, starting from reset.
        reset_n_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v_i = 4'b1010; cache_v_i = (i > 0); resp_yumi_i = 4'b1111;
            #2;
            check_eq($sformatf("skip_pkt%0d", i),   32'(cache_pkt_o), (i % 2) ? 32'h13 : 32'h11);
            check_eq($sformatf("skip_ready%0d", i), 32'(ready_o),     (i % 2) ? 32'h8 : 32'h2);
            step();
        end
        v_i = '0; cache_v_i = 1'b1;
        step();
        cache_v_i = 1'b0;
        check_eq("skip_outst", 32'(outstanding_o), 32'd0);

        // Full FIFO back-pressure, no responses.
        acc = 0;
        v_i = 4'b1111; resp_yumi_i = '0;
        for (int i = 0; i < 6; i++) begin
            #2;
            if (cache_v_o && cache_ready_i) acc++;
            if (i >= 4) check_eq($sformatf("full_ready%0d", i), 32'(ready_o), 32'h0);
            step();
        end
        check_eq("full_accepts", 32'(acc),           32'd4);
        check_eq("full_outst",   32'(outstanding_o), 32'd4);
        cache_v_i = 1'b1; resp_yumi_i = 4'b1111;
        #2;
        check_eq("full_pop_ready",   32'(ready_o),      32'h0);
        check_eq("full_pop_cache_v", 32'(cache_v_o),    32'h0);
        check_eq("full_pop_yumi",    32'(cache_yumi_o), 32'h1);
        check_eq("full_pop_resp_v",  32'(resp_v_o),     32'h1);
        step();
        check_eq("full_after_pop", 32'(outstanding_o), 32'd3);
        v_i = '0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_eq($sformatf("full_drain_resp_v%0d", i), 32'(resp_v_o), 32'(1) << (i + 1));
            step();
        end
        cache_v_i = 1'b0; resp_yumi_i = '0;
        check_eq("full_drain_outst", 32'(outstanding_o), 32'd0);

        // Response routing: requests from 2, 0, 2.
        req_seq  = '{2, 0, 2};
        exp_data = '{8'h0A, 8'h0B, 8'h0C};
        for (int i = 0; i < 3; i++) begin
            v_i = 4'(1 << req_seq[i]);
            #2;
            check_eq($sformatf("route_ready%0d", i), 32'(ready_o), 32'(1) << req_seq[i]);
            step();
        end
        v_i = '0;
        check_eq("route_outst", 32'(outstanding_o), 32'd3);
        cache_v_i = 1'b1; cache_data_i = 8'h0A; resp_yumi_i = '0;
        #2;
        check_eq("route_stall_resp_v", 32'(resp_v_o),     32'h4);
        check_eq("route_stall_data",   32'(resp_data_o),  32'h0A);
        check_eq("route_stall_yumi",   32'(cache_yumi_o), 32'h0);
        step();
        check_eq("route_stall_outst", 32'(outstanding_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            cache_data_i = exp_data[i]; resp_yumi_i = 4'(1 << req_seq[i]);
            #2;
            check_eq($sformatf("route_resp_v%0d", i), 32'(resp_v_o),     32'(1) << req_seq[i]);
            check_eq($sformatf("route_data%0d", i),   32'(resp_data_o),  32'(exp_data[i]));
            check_eq($sformatf("route_yumi%0d", i),   32'(cache_yumi_o), 32'h1);
            step();
        end
        cache_v_i = 1'b0; resp_yumi_i = '0;
        check_eq("route_end_outst", 32'(outstanding_o), 32'd0);

        // Simultaneous push and pop at occupancy 2 (priority pointer is at 3).
        v_i = 4'b0010;
        #2;
        check_eq("pp_ready_a", 32'(ready_o), 32'h2);
        step();
        v_i = 4'b1000;
        #2;
        check_eq("pp_ready_b", 32'(ready_o), 32'h8);
        step();
        check_eq("pp_outst_2", 32'(outstanding_o), 32'd2);
        v_i = 4'b0001; cache_v_i = 1'b1; cache_data_i = 8'h55; resp_yumi_i = 4'b0010;
        #2;
        check_eq("pp_ready_c", 32'(ready_o),      32'h1);
        check_eq("pp_resp_v",  32'(resp_v_o),     32'h2);
        check_eq("pp_yumi",    32'(cache_yumi_o), 32'h1);
        step();
        check_eq("pp_outst_same", 32'(outstanding_o), 32'd2);
        exp_id = '{3, 0, 0};
        v_i = '0;
        for (int i = 0; i < 2; i++) begin
            resp_yumi_i = 4'(1 << exp_id[i]);
            #2;
            check_eq($sformatf("pp_order%0d", i), 32'(resp_v_o), 32'(1) << exp_id[i]);
            step();
        end
        cache_v_i = 1'b0; resp_yumi_i = '0;
        check_eq("pp_end_outst", 32'(outstanding_o), 32'd0);

        // Reset mid-operation with 3 outstanding (priority pointer at 1: grants 1,2,3).
        v_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_eq($sformatf("mid_ready%0d", i), 32'(ready_o), 32'(1) << (i + 1));
            step();
        end
        check_eq("mid_outst", 32'(outstanding_o), 32'd3);
        reset_n_i = 1'b0; cache_v_i = 1'b1; resp_yumi_i = 4'b1111;
        #2;
        check_eq("mid_rst_ready",   32'(ready_o),       32'h0);
        check_eq("mid_rst_cache_v", 32'(cache_v_o),     32'h0);
        check_eq("mid_rst_resp_v",  32'(resp_v_o),      32'h0);
        check_eq("mid_rst_yumi",    32'(cache_yumi_o),  32'h0);
        check_eq("mid_rst_outst",   32'(outstanding_o), 32'd0);
        step();
        reset_n_i = 1'b1; cache_v_i = 1'b0; resp_yumi_i = '0; v_i = 4'b1110;
        #2;
        check_eq("mid_post_outst", 32'(outstanding_o), 32'd0);
        check_eq("mid_post_ready", 32'(ready_o),       32'h2);
        check_eq("mid_post_pkt",   32'(cache_pkt_o),   32'h11);
        step();
        check_eq("mid_post_outst1", 32'(outstanding_o), 32'd1);
        v_i = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
